// File: rtl/hard_mem_1rw_init_requester.sv
// ----------------------------------------------------------------------------
// hard_mem_1rw_init_requester
//
// This block sits between a cache or tag client and a hard_mem_1rw byte-mask
// wrapper, and drives that wrapper.
//
// Start-up:
//   - After reset the block writes INIT_VAL to every entry, at addresses
//     0..ELS-1, one per cycle.
//   - It then hands the memory port to the client through a ready/valid
//     handshake.
//
// Client reads:
//   - Each accepted read returns one registered response.
//   - That response is held until the client consumes it with yumi_i.
//   - Only one read can be in flight at a time.
//
// Optional feature, macro HARD_MEM_INIT_VERIFY_EN:
//   - When the macro is defined, an extra read-back pass follows the fill.
//   - That pass compares each entry against INIT_VAL.
//   - Any mismatch sets the sticky init_err_o.
//   - When the macro is undefined, the fill goes straight to normal operation
//     and init_err_o is tied to 0.
//
// Ports:
//   clk_i, reset_n_i           clock, synchronous active-low reset
//   v_i, w_i, addr_i, data_i,  client request (valid, write, address,
//   w_mask_i                   write data, byte mask)
//   ready_o                    request accepted this cycle when v_i=1
//   v_o, data_o, yumi_i        registered read response and its consume strobe
//   mem_v_o, mem_w_o,          memory access towards the wrapper
//   mem_addr_o, mem_data_o,
//   mem_w_mask_o
//   mem_data_i                 wrapper read data, valid 1 cycle after the read edge
//   init_done_o                fill (and verify) finished; held until next reset
//   init_err_o                 sticky verify mismatch
// ----------------------------------------------------------------------------
module hard_mem_1rw_init_requester #(
    parameter int unsigned      ELS      = 512,
    parameter int unsigned      WIDTH    = 64,
    parameter int unsigned      MASK_W   = WIDTH / 8,
    parameter int unsigned      ADDR_W   = $clog2(ELS),
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk_i,
    input  logic              reset_n_i,

    input  logic              v_i,
    input  logic              w_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic [MASK_W-1:0] w_mask_i,
    output logic              ready_o,

    output logic              v_o,
    output logic [WIDTH-1:0]  data_o,
    input  logic              yumi_i,

    output logic              mem_v_o,
    output logic              mem_w_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WIDTH-1:0]  mem_data_o,
    output logic [MASK_W-1:0] mem_w_mask_o,
    input  logic [WIDTH-1:0]  mem_data_i,

    output logic              init_done_o,
    output logic              init_err_o
);

    typedef enum logic [1:0] {
        StInitWr = 2'd0,
        StInitRd = 2'd1,
        StRun    = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(ELS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              resp_v_q, resp_v_d;
    logic [WIDTH-1:0]  data_q, data_d;

    logic              cnt_last;
    logic              run_ready;
    logic              accept;

    assign cnt_last = (cnt_q == LastAddr);

    // The client may only enter when no read is outstanding and the held
    // response slot is either empty or being consumed this very cycle.
    assign run_ready = (state_q == StRun) & ~rd_pend_q & (~resp_v_q | yumi_i);
    assign accept    = v_i & run_ready;

`ifdef HARD_MEM_INIT_VERIFY_EN
    // rd_tail: one extra cycle after the last verify read, so that the final
    //   returned word can still be compared before normal operation starts.
    // chk_v: the word on mem_data_i this cycle belongs to a verify read.
    logic rd_tail_q, rd_tail_d;
    logic chk_v_q, chk_v_d;
    logic err_q, err_d;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= StInitWr;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            resp_v_q  <= 1'b0;
            data_q    <= '0;
`ifdef HARD_MEM_INIT_VERIFY_EN
            rd_tail_q <= 1'b0;
            chk_v_q   <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            resp_v_q  <= resp_v_d;
            data_q    <= data_d;
`ifdef HARD_MEM_INIT_VERIFY_EN
            rd_tail_q <= rd_tail_d;
            chk_v_q   <= chk_v_d;
            err_q     <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInitWr: begin
                if (cnt_last) begin
`ifdef HARD_MEM_INIT_VERIFY_EN
                    state_d = StInitRd;
`else
                    state_d = StRun;
`endif
                end
            end
`ifdef HARD_MEM_INIT_VERIFY_EN
            StInitRd: begin
                if (rd_tail_q) begin
                    state_d = StRun;
                end
            end
`endif
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StInitWr;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next-state: init address counter, read pipeline, verify
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StInitWr) begin
            cnt_d = cnt_last ? '0 : cnt_q + ADDR_W'(1);
        end
`ifdef HARD_MEM_INIT_VERIFY_EN
        if (state_q == StInitRd && !rd_tail_q) begin
            cnt_d = cnt_last ? '0 : cnt_q + ADDR_W'(1);
        end
`endif

        // The read data lands one cycle after the read edge. It is captured
        // exactly in the cycle that rd_pend_q is set.
        rd_pend_d = accept & ~w_i;

        resp_v_d = resp_v_q;
        data_d   = data_q;
        if (rd_pend_q) begin
            resp_v_d = 1'b1;
            data_d   = mem_data_i;
        end else if (yumi_i) begin
            resp_v_d = 1'b0;
        end
    end

`ifdef HARD_MEM_INIT_VERIFY_EN
    always_comb begin
        rd_tail_d = (state_q == StInitRd) & ~rd_tail_q & cnt_last;
        chk_v_d   = (state_q == StInitRd) & ~rd_tail_q;
        err_d     = err_q | (chk_v_q & (mem_data_i != INIT_VAL));
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        ready_o      = 1'b0;
        mem_v_o      = 1'b0;
        mem_w_o      = 1'b0;
        mem_addr_o   = cnt_q;
        mem_data_o   = INIT_VAL;
        mem_w_mask_o = '1;
        init_done_o  = 1'b0;
        unique case (state_q)
            StInitWr: begin
                mem_v_o = 1'b1;
                mem_w_o = 1'b1;
            end
`ifdef HARD_MEM_INIT_VERIFY_EN
            StInitRd: begin
                mem_v_o = ~rd_tail_q;
            end
`endif
            StRun: begin
                init_done_o  = 1'b1;
                ready_o      = run_ready;
                mem_v_o      = accept;
                mem_w_o      = accept & w_i;
                mem_addr_o   = addr_i;
                mem_data_o   = data_i;
                mem_w_mask_o = w_mask_i;
            end
            default: begin
                mem_v_o = 1'b0;
            end
        endcase
    end

    assign v_o    = resp_v_q;
    assign data_o = data_q;

`ifdef HARD_MEM_INIT_VERIFY_EN
    assign init_err_o = err_q;
`else
    assign init_err_o = 1'b0;
`endif

`ifndef SYNTHESIS
    // Consuming a response that does not exist is a client protocol error.
    yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> resp_v_q
    );
`endif

endmodule
